// File: rtl/spi_pkg.sv
// Shared SPI types and mode constants for the FIFO-side SPI transmitter and receiver.
`default_nettype none

package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    GAP  = 2'd3
  } spi_tx_state_t;

  // Mode 0: sclk idles low, data is sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  function automatic int spi_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_half_period_cnt.sv
// Free-running divider while enabled; pulses tc_o on the last cycle of a limit_i-long period.
`default_nettype none

module spi_half_period_cnt #(
  parameter int Width = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == (limit_i - Width'(1)));

  always_comb begin
    cnt_d = cnt_q + Width'(1);
    if (!en_i || tc_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/spi_fifo_drain_tx.sv
// SPI mode-0 master transmitter: pops one FIFO word per cs_n frame and shifts it out MSB-first.
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module spi_fifo_drain_tx
  import spi_pkg::*;
#(
  parameter int DataWidth = `DATA_WIDTH,
  parameter int ClkDiv    = 2,
  parameter int GapCycles = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 empty,
  input  logic [DataWidth-1:0] readData,
  output logic                 readEn,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 cs_n,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CntW = $clog2(spi_max(ClkDiv, GapCycles) + 1);
  localparam int BitW = $clog2(DataWidth + 1);

  spi_tx_state_t        state_q, state_d;
  logic [DataWidth-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]      bitcnt_q, bitcnt_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 cs_n_q, cs_n_d;
  logic                 frame_done_q, frame_done_d;
  logic [CntW-1:0]      limit;
  logic                 tc;

  assign limit = (state_q == GAP) ? CntW'(GapCycles) : CntW'(ClkDiv);

  spi_half_period_cnt #(.Width(CntW)) u_div (
    .clk     (clk),
    .rst_n   (rst),
    .en_i    (state_q != IDLE),
    .limit_i (limit),
    .tc_o    (tc)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    cs_n_d       = cs_n_q;
    frame_done_d = 1'b0;
    readEn       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gated by reset so the FIFO never loses a word the held-in-reset FSM cannot take.
        if (enable && !empty && rst) begin
          readEn   = 1'b1;
          shreg_d  = readData;
          mosi_d   = readData[DataWidth-1];
          cs_n_d   = 1'b0;
          bitcnt_d = '0;
          state_d  = LOW;
        end
      end
      LOW: begin
        if (tc) begin
          if (bitcnt_q == BitW'(DataWidth)) begin
            cs_n_d       = 1'b1;
            frame_done_d = 1'b1;
            state_d      = GAP;
          end else begin
            sclk_d  = 1'b1;
            state_d = HIGH;
          end
        end
      end
      HIGH: begin
        if (tc) begin
          sclk_d   = 1'b0;
          bitcnt_d = bitcnt_q + BitW'(1);
          shreg_d  = shreg_q << 1;
          // Zeros shifted in make this 0 after the last bit.
          mosi_d   = shreg_q[DataWidth-2];
          state_d  = LOW;
        end
      end
      GAP: begin
        if (tc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      sclk_q       <= SPI_CPOL;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      cs_n_q       <= cs_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign cs_n       = cs_n_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_fifo_drain_tx.sv
// Directed bench for spi_fifo_drain_tx with a queue-based FIFO model and an SPI frame decoder.
`default_nettype none

module tb_spi_fifo_drain_tx;

  localparam int DW = 8;
  localparam int CD = 2;
  localparam int GC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          empty = 1'b1;
  logic [DW-1:0] readData = '0;
  logic          readEn, sclk, mosi, cs_n, busy, frame_done;

  always #5 clk = ~clk;

  spi_fifo_drain_tx #(.DataWidth(DW), .ClkDiv(CD), .GapCycles(GC)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .empty      (empty),
    .readData   (readData),
    .readEn     (readEn),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // FIFO model: data/empty refreshed on the falling edge, popped on the rising edge.
  logic [DW-1:0] fifo[$];
  int rden_cycles = 0;
  int pop_empty_viol = 0;
  int pop_times[$];

  always @(posedge clk) begin
    cyc++;
    if (readEn === 1'b1) begin
      rden_cycles++;
      if (empty || fifo.size() == 0) pop_empty_viol++;
      else begin
        void'(fifo.pop_front());
        pop_times.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    empty    = (fifo.size() == 0);
    readData = (fifo.size() == 0) ? '0 : fifo[0];
  end

  // SPI decoder: collects mosi on sclk rises inside each cs_n low window.
  logic          prev_sclk = 1'b0;
  logic          prev_cs = 1'b1;
  logic [DW-1:0] acc = '0;
  int rises = 0, low_len = 0, high_run = 0, fd_cnt = 0;
  int frm_word[$], frm_rises[$], frm_low[$], frm_gap[$];

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (cs_n === 1'b0) begin
      if (prev_cs) begin
        frm_gap.push_back(high_run);
        acc = '0;
        rises = 0;
        low_len = 0;
      end
      low_len++;
      if (sclk && !prev_sclk) begin
        acc = {acc[DW-2:0], mosi};
        rises++;
      end
      high_run = 0;
    end else begin
      if (!prev_cs) begin
        frm_word.push_back(int'(acc));
        frm_rises.push_back(rises);
        frm_low.push_back(low_len);
      end
      high_run++;
    end
    prev_sclk = sclk;
    prev_cs   = cs_n;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    @(posedge clk);
    #1;
    fifo.push_back(w);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frm_word.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (frm_word.size() < n) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d frames expected %0d", frm_word.size(), n);
    end
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k;
    k = 0;
    while (!(cs_n === 1'b0 && rises >= n) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!(cs_n === 1'b0 && rises >= n)) begin
      checks++;
      errors++;
      $display("FAIL rise_timeout: got %0d rises expected %0d", rises, n);
    end
  endtask

  task automatic clear_mon();
    frm_word.delete();
    frm_rises.delete();
    frm_low.delete();
    frm_gap.delete();
    pop_times.delete();
    fd_cnt = 0;
    rden_cycles = 0;
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] exp_bits;
  } vec_t;

  vec_t tbl[6];
  int   idle_bad;

  initial begin
    tbl[0] = '{8'h00, 8'b0000_0000};
    tbl[1] = '{8'hFF, 8'b1111_1111};
    tbl[2] = '{8'h80, 8'b1000_0000};
    tbl[3] = '{8'h01, 8'b0000_0001};
    tbl[4] = '{8'hC3, 8'b1100_0011};
    tbl[5] = '{8'h69, 8'b0110_1001};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_readEn", 32'(readEn), 32'd0);
    rst = 1'b1;
    enable = 1'b1;

    // Single word 0xA5
    clear_mon();
    push(8'hA5);
    wait_frames(1, 200);
    repeat (5) @(negedge clk);
    if (frm_word.size() >= 1) begin
      chk("t1_word", 32'(frm_word[0]), 32'h0000_00A5);
      chk("t1_rises", 32'(frm_rises[0]), 32'd8);
      chk("t1_cs_low", 32'(frm_low[0]), 32'd34);
    end
    chk("t1_readEn_cycles", 32'(rden_cycles), 32'd1);
    chk("t1_frame_done", 32'(fd_cnt), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // Back-to-back 0x3C, 0xFF
    clear_mon();
    push(8'h3C);
    push(8'hFF);
    wait_frames(2, 300);
    repeat (5) @(negedge clk);
    if (frm_word.size() >= 2 && pop_times.size() >= 2) begin
      chk("t2_word0", 32'(frm_word[0]), 32'h0000_003C);
      chk("t2_word1", 32'(frm_word[1]), 32'h0000_00FF);
      chk("t2_cs_low1", 32'(frm_low[1]), 32'd34);
      // cs_n is high through GAP plus the IDLE cycle in which the next pop is issued.
      chk("t2_cs_high_gap", 32'(frm_gap[1]), 32'(GC + 1));
      chk("t2_pop_spacing", 32'(pop_times[1] - pop_times[0]), 32'd37);
    end
    chk("t2_fifo_empty", 32'(fifo.size()), 32'd0);
    chk("t2_frame_done", 32'(fd_cnt), 32'd2);

    // Empty FIFO, enable held
    clear_mon();
    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (readEn !== 1'b0 || cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) idle_bad++;
    end
    chk("t3_idle_violations", 32'(idle_bad), 32'd0);
    chk("t3_readEn_cycles", 32'(rden_cycles), 32'd0);

    // enable dropped mid-frame
    clear_mon();
    push(8'h81);
    push(8'h5A);
    wait_rises(3, 200);
    enable = 1'b0;
    wait_frames(1, 200);
    repeat (60) @(negedge clk);
    if (frm_word.size() >= 1) begin
      chk("t4_word", 32'(frm_word[0]), 32'h0000_0081);
      chk("t4_rises", 32'(frm_rises[0]), 32'd8);
    end
    chk("t4_held_fifo", 32'(fifo.size()), 32'd1);
    chk("t4_readEn_cycles", 32'(rden_cycles), 32'd1);
    enable = 1'b1;
    wait_frames(2, 200);
    if (frm_word.size() >= 2) chk("t4_resumed_word", 32'(frm_word[1]), 32'h0000_005A);

    // Reset during the 5th bit
    repeat (5) @(negedge clk);
    clear_mon();
    push(8'h11);
    push(8'h22);
    wait_rises(5, 200);
    rst = 1'b0;
    #1;
    chk("t5_cs_n", 32'(cs_n), 32'd1);
    chk("t5_sclk", 32'(sclk), 32'd0);
    chk("t5_mosi", 32'(mosi), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("t5_no_pop_in_reset", 32'(fifo.size()), 32'd1);
    rst = 1'b1;
    clear_mon();
    wait_frames(1, 200);
    if (frm_word.size() >= 1) chk("t5_next_word", 32'(frm_word[0]), 32'h0000_0022);
    chk("t5_readEn_cycles", 32'(rden_cycles), 32'd1);

    // Table-driven stream
    repeat (5) @(negedge clk);
    clear_mon();
    for (int i = 0; i < 6; i++) push(tbl[i].data);
    wait_frames(6, 400);
    for (int i = 0; i < 6; i++) begin
      if (frm_word.size() > i) begin
        chk($sformatf("t6_word%0d", i), 32'(frm_word[i]), 32'(tbl[i].exp_bits));
        chk($sformatf("t6_rises%0d", i), 32'(frm_rises[i]), 32'd8);
      end
    end
    repeat (5) @(negedge clk);
    chk("t6_frame_done", 32'(fd_cnt), 32'd6);
    chk("t6_fifo_empty", 32'(fifo.size()), 32'd0);
    chk("pop_while_empty", 32'(pop_empty_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d errors before timeout", errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
